// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA frame reader.
// Holds the 1024x768@60 default parameter set, the derived line/frame
// totals, the read-side FSM state type and a sync-window helper.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN
  } rd_state_e;

  // True while cnt lies in the sync window [start, start+width).
  function automatic logic in_sync(input int unsigned cnt,
                                   input int unsigned start,
                                   input int unsigned width);
    return (cnt >= start) && (cnt < start + width);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and stage-0 timing strobes.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   de0        active-video region (combinational from counters)
//   hs0, vs0   inside the h/v sync window (active-high, polarity applied later)
//   frame_end  last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1)
//   toggle_pt  first pixel of the first blanking line (h=0, v=V_ACTIVE)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic de0,
  output logic hs0,
  output logic vs0,
  output logic frame_end,
  output logic toggle_pt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    de0       = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs0       = in_sync(32'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
    vs0       = in_sync(32'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
    frame_end = h_last && v_last;
    toggle_pt = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
  end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out front end for the SDRAM arbiter read port.
// Arms on mem_rdy, starts reading at the next frame boundary and pops one
// RGB565 word per active pixel; pulses mem_toggle once per frame so the
// arbiter can swap buffers. Missing FIFO data is shown black and counted.
// Ports:
//   clk_mem_rd, rst      pixel clock, synchronous active-high reset
//   mem_rdy              arbiter initialised (level)
//   mem_rd_rdy           read FIFO non-empty
//   mem_rd_req           pop one word; mem_dout valid next cycle
//   mem_dout[15:0]       read data
//   mem_toggle           one-cycle end-of-frame strobe
//   vga_hs/vga_vs/vga_de registered sync and data enable
//   vga_rgb[15:0]        pixel, black outside active video or on underrun
//   underrun             sticky underrun flag
//   underrun_cnt[15:0]   saturating underrun pixel count
module vga_frame_reader
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_mem_rd,
  input  logic        rst,
  input  logic        mem_rdy,
  input  logic        mem_rd_rdy,
  output logic        mem_rd_req,
  input  logic [15:0] mem_dout,
  output logic        mem_toggle,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  logic de0, hs0, vs0, frame_end, toggle_pt;
  rd_state_e state, state_nxt;
  logic px_underrun;
  logic req_d;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk_mem_rd),
    .rst       (rst),
    .de0       (de0),
    .hs0       (hs0),
    .vs0       (vs0),
    .frame_end (frame_end),
    .toggle_pt (toggle_pt)
  );

  always_ff @(posedge clk_mem_rd) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reads only start on a frame boundary so the pixel stream stays aligned
  // with the buffer the arbiter reloads on mem_toggle.
  always_comb begin
    state_nxt   = state;
    mem_rd_req  = 1'b0;
    px_underrun = 1'b0;
    mem_toggle  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_rdy) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        mem_toggle = toggle_pt;
        if (!mem_rdy) state_nxt = ST_IDLE;
        else if (frame_end) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mem_toggle  = toggle_pt;
        mem_rd_req  = de0 & mem_rd_rdy;
        px_underrun = de0 & ~mem_rd_rdy;
        if (!mem_rdy && frame_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem_rd) begin
    if (rst) begin
      vga_hs       <= ~SYNC_POL;
      vga_vs       <= ~SYNC_POL;
      vga_de       <= 1'b0;
      req_d        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      vga_hs <= hs0 ? SYNC_POL : ~SYNC_POL;
      vga_vs <= vs0 ? SYNC_POL : ~SYNC_POL;
      vga_de <= de0;
      req_d  <= mem_rd_req;
      if (px_underrun) begin
        underrun <= 1'b1;
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  // mem_dout arrives one cycle after the pop, aligned with the registered vga_de.
  assign vga_rgb = req_d ? mem_dout : '0;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Downstream consumer of the SDRAM memory arbiter's read port: generates 1024x768@60 VGA timing and pulls one 16-bit RGB565 pixel per active pixel clock from the arbiter's read FIFO. It arms itself on `mem_rdy` and pulses `mem_toggle` once per frame so the arbiter reloads the read address and swaps buffers. It outputs registered sync, data enable and pixel data, and flags FIFO underruns.

## Interface
- `H_ACTIVE`, 1024, active pixels per line
- `H_FP`, 24, horizontal front porch, pixels
- `H_SYNC`, 136, hsync width, pixels
- `H_BP`, 160, horizontal back porch, pixels
- `V_ACTIVE`, 768, active lines
- `V_FP`, 3, vertical front porch, lines
- `V_SYNC`, 6, vsync width, lines
- `V_BP`, 29, vertical back porch, lines
- `SYNC_POL`, 0, sync active level (0 = active-low)

Ports:
- `clk_mem_rd`  in  1  pixel clock (65 MHz), same clock as the arbiter read port
- `rst`  in  1  synchronous, active-high reset
- `mem_rdy`  in  1  arbiter initialised; level
- `mem_rd_rdy`  in  1  read FIFO holds at least one word
- `mem_rd_req`  out  1  pop one word; `mem_dout` valid next cycle
- `mem_dout`  in  16  RGB565 read data
- `mem_toggle`  out  1  one-cycle end-of-frame pulse to the arbiter
- `vga_hs`  out  1  horizontal sync
- `vga_vs`  out  1  vertical sync
- `vga_de`  out  1  active-video enable
- `vga_rgb`  out  16  RGB565 pixel; 0 outside active video or on underrun
- `underrun`  out  1  sticky: an active pixel found the FIFO empty
- `underrun_cnt`  out  16  saturating count of underrun pixels

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (1344); width is clog2(H_TOTAL).
  - `v_cnt` runs 0..V_TOTAL-1 (806) and increments when `h_cnt` wraps.
  - Both wrap to 0 together at the frame end.
- Stage 0 (combinational from counters):
  - `de0` = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - `hs0` is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - `vs0` is the same rule applied to `v_cnt`.
- FSM states:
  - IDLE: counters run and syncs are generated; no reads. Go to ARMED when `mem_rdy`=1.
  - ARMED: wait for the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, then go to RUN.
  - RUN: `mem_rd_req` = de0 & mem_rd_rdy. If `mem_rdy` deasserts, return to IDLE at the next frame end.
- Underrun rule:
  - Applies in RUN when de0=1 and mem_rd_rdy=0.
  - No request is issued; the pixel is output black.
  - `underrun` is set; `underrun_cnt` increments and saturates at 0xFFFF.
  - No catch-up: the read stream continues with the next pixel.
- `mem_toggle` pulses for one cycle at h_cnt=0, v_cnt=V_ACTIVE (first blanking line) in ARMED or RUN. It does not pulse in IDLE.
- In IDLE or ARMED, `vga_de` still follows the timing and `vga_rgb`=0.

## Timing
- Stage 1 registers `hs0`, `vs0`, `de0` and "req issued" into `vga_hs`, `vga_vs`, `vga_de` and `req_d`.
- `vga_rgb` = req_d ? mem_dout : 0. The pixel appears on the same cycle as its `vga_de`.
- Latency: counter to outputs is 1 cycle. `mem_rd_req` to pixel on `vga_rgb` is 1 cycle.
- `mem_rd_req` is never asserted when mem_rd_rdy=0 and never asserted outside active video.
- Exactly H_ACTIVE×V_ACTIVE requests are issued per underrun-free frame.
- Reset values:
  - h_cnt=0, v_cnt=0, state IDLE.
  - `mem_rd_req`=0, `mem_toggle`=0, `vga_de`=0, `vga_rgb`=0.
  - `vga_hs`/`vga_vs` at the inactive level (!SYNC_POL).
  - `underrun`=0, `underrun_cnt`=0.
- Reset mid-frame: all of the above apply on the next edge. Any FIFO contents are the arbiter's responsibility; this block reads nothing until re-armed.

## Structure
- Shared package `vga_timing_pkg`:
  - constants for the 1024x768@60 parameter set and derived H_TOTAL/V_TOTAL;
  - a sync-region helper function.
- One sub-module, `vga_timing_gen`: counters, hs0/vs0/de0, frame-end and toggle strobes.
- The top level holds the FSM, read request, output stage and underrun logic.

## Test plan
- Reset, then idle 1 frame with mem_rdy=0 → no `mem_rd_req`, no `mem_toggle`; hs low for 136 clks every 1344; vs low for 6 lines every 806.
- mem_rdy=1 mid-frame, FIFO always ready, `mem_dout`=incrementing pattern → first req at (0,0) of the next frame; `vga_rgb` equals the popped word 1 cycle later; 786432 reqs per frame.
- Drop mem_rd_rdy for 5 active cycles at line 10 → 5 black pixels; `underrun`=1; `underrun_cnt`=5; remaining pixels continue in order.
- Check `mem_toggle` → exactly one 1-cycle pulse per frame at h=0, v=768 once armed.
- Assert `rst` at h=500, v=300 → next cycle all outputs at reset values; state IDLE; re-arm waits for a full frame boundary.
- Force 70000 underruns → `underrun_cnt` holds at 0xFFFF.
